// File: rtl/prefetch_queue.sv
// prefetch_queue
//   Byte-wide instruction prefetch queue. It requests sequential code bytes
//   from the bus FSM, stores each returned byte in a circular FIFO, and
//   presents the oldest two bytes to the core as a little-endian word. A
//   flush restarts fetching at a new address and discards any byte in flight.
//
// Ports
//   clk          system clock, rising edge
//   rst          asynchronous active-high reset
//   flush        discard queue and in-flight byte, restart at flush_addr
//   flush_addr   new physical fetch address (sampled with flush)
//   fetch_req    request one code-byte bus cycle
//   fetch_addr   physical address of the next byte to fetch
//   bus_grant    pulse: bus FSM accepted fetch_req
//   bus_valid    pulse: bus_data holds the granted byte
//   bus_data     byte from the AD bus
//   rd_en        core consumes bytes from the head this cycle
//   rd_len       0 = consume one byte, 1 = consume two bytes
//   q_data       {head+1, head}; invalid positions read 8'h00
//   q_level      number of valid bytes
//   underflow    registered pulse: a read asked for more bytes than q_level
//   fsm_state_o  fetch FSM state (0 = IDLE, 1 = WAIT, 2 = DROP)
//
// Handshake: fetch_req is a request level; bus_grant acknowledges it with a
// single-cycle pulse, after which exactly one bus_valid pulse returns the
// byte. Only one fetch is ever outstanding.
module prefetch_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 20
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic [AW-1:0]            flush_addr,
  output logic                     fetch_req,
  output logic [AW-1:0]            fetch_addr,
  input  logic                     bus_grant,
  input  logic                     bus_valid,
  input  logic [7:0]               bus_data,
  input  logic                     rd_en,
  input  logic                     rd_len,
  output logic [15:0]              q_data,
  output logic [$clog2(DEPTH):0]   q_level,
  output logic                     underflow,
  output logic [1:0]               fsm_state_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]   level_q, level_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic            uf_q, uf_d;
  logic [7:0]      mem_q [DEPTH];

  logic [LW-1:0]   need;
  logic            rd_ok;
  logic            push;
  logic [PW-1:0]   rd_ptr_p1;

  assign need  = rd_len ? LW'(2) : LW'(1);
  assign rd_ok = rd_en && (need <= level_q);
  // A returned byte is kept only for a live fetch that is not being flushed.
  assign push  = (state_q == S_WAIT) && bus_valid && !flush;

  // Held low during reset so the request never escapes while state is forced.
  assign fetch_req = !rst && (state_q == S_IDLE) && (level_q < LW'(DEPTH)) && !flush;

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    addr_d   = addr_q;
    uf_d     = 1'b0;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
      addr_d   = flush_addr;
      case (state_q)
        // A grant coinciding with flush still owns a bus cycle whose byte
        // must be swallowed.
        S_IDLE:  state_d = bus_grant ? S_DROP : S_IDLE;
        S_WAIT,
        S_DROP:  state_d = bus_valid ? S_IDLE : S_DROP;
        default: state_d = S_IDLE;
      endcase
    end else begin
      case (state_q)
        S_IDLE: if (bus_grant && fetch_req) state_d = S_WAIT;
        S_WAIT: if (bus_valid) begin
          state_d  = S_IDLE;
          wr_ptr_d = wr_ptr_q + PW'(1);
          addr_d   = addr_q + AW'(1);
        end
        S_DROP: if (bus_valid) state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
      if (rd_en) begin
        if (rd_ok) rd_ptr_d = rd_ptr_q + PW'(need);
        uf_d = !rd_ok;
      end
      level_d = level_q + LW'(push) - (rd_ok ? need : LW'(0));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      addr_q   <= AW'(20'hFFFF0);
      uf_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      addr_q   <= addr_d;
      uf_q     <= uf_d;
    end
  end

  // Storage needs no reset: q_data masks positions beyond q_level.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= bus_data;
  end

  assign rd_ptr_p1   = rd_ptr_q + PW'(1);
  assign q_data      = {(level_q >= LW'(2)) ? mem_q[rd_ptr_p1] : 8'h00,
                        (level_q != '0)     ? mem_q[rd_ptr_q]  : 8'h00};
  assign q_level     = level_q;
  assign fetch_addr  = addr_q;
  assign underflow   = uf_q;
  assign fsm_state_o = state_q;

endmodule
